md_unit: RTL and testbench

//  Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It executes

---
 rtl/md_unit.sv | 137 +++++++++++++
 tb/tb_md_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency mult/multu/div/divu
// plus mthi/mtlo writes; the 4-bit down-counter doubles as the IDLE/RUN state.
module md_unit #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic        mthl,
   input  logic        hl_sel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   state_t      state_s;
   logic [3:0]  cnt_r, cnt_s;
   logic [31:0] a_r, a_s, b_r, b_s;
   logic [1:0]  op_r, op_s;
   logic [31:0] hi_s, lo_s;
   logic        busy_s;
   logic [63:0] res_s;

   // Packs the result as {hi, lo}; signed divide works on magnitudes then fixes signs.
   function automatic logic [63:0] md_result(input logic [1:0] op,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
      logic [63:0] prod;
      logic [31:0] mx, my, q, r;
      prod = 64'd0;
      mx   = 32'd0;
      my   = 32'd0;
      q    = 32'd0;
      r    = 32'd0;
      case (op)
         2'b00: prod = {{32{x[31]}}, x} * {{32{y[31]}}, y};
         2'b01: prod = {32'd0, x} * {32'd0, y};
         2'b10: begin
            mx = x[31] ? (32'd0 - x) : x;
            my = y[31] ? (32'd0 - y) : y;
            if (my != 32'd0) begin
               q = mx / my;
               r = mx % my;
            end else begin
               q = 32'd0;
               r = 32'd0;
            end
            q    = (x[31] ^ y[31]) ? (32'd0 - q) : q;
            r    = x[31] ? (32'd0 - r) : r;
            prod = {r, q};
         end
         2'b11: begin
            if (y != 32'd0) begin
               prod = {x % y, x / y};
            end else begin
               prod = 64'd0;
            end
         end
         default: prod = 64'd0;
      endcase
      return prod;
   endfunction

   // Next-state: issue/mthl handling in IDLE, countdown and result write-back in RUN.
   always_comb begin
      state_s = (cnt_r != 4'd0) ? RUN : IDLE;
      res_s   = md_result(op_r, a_r, b_r);
      cnt_s   = cnt_r;
      a_s     = a_r;
      b_s     = b_r;
      op_s    = op_r;
      hi_s    = hi;
      lo_s    = lo;
      case (state_s)
         IDLE: begin
            if (start) begin
               a_s   = a;
               b_s   = b;
               op_s  = md_op;
               cnt_s = md_op[1] ? DIV_CNT : MULT_CNT;
            end else if (mthl) begin
               if (hl_sel) begin
                  hi_s = a;
               end else begin
                  lo_s = a;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         RUN: begin
            cnt_s = cnt_r - 4'd1;
            // Divide by zero runs the full latency but leaves HI/LO untouched.
            if ((cnt_r == 4'd1) && !(op_r[1] && (b_r == 32'd0))) begin
               hi_s = res_s[63:32];
               lo_s = res_s[31:0];
            end else begin
               hi_s = hi;
               lo_s = lo;
            end
         end
         default: cnt_s = 4'd0;
      endcase
      busy_s = (cnt_s != 4'd0);
   end

   // State, operand latches and architectural HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= 4'd0;
         a_r   <= 32'd0;
         b_r   <= 32'd0;
         op_r  <= 2'b00;
         busy  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         cnt_r <= cnt_s;
         a_r   <= a_s;
         b_r   <= b_s;
         op_r  <= op_s;
         busy  <= busy_s;
         hi    <= hi_s;
         lo    <= lo_s;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: issued operations queue their expected HI/LO and busy
// length; a monitor checks each completion when busy falls.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  md_op;
   logic        mthl;
   logic        hl_sel;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   prev_busy = 1'b0;
   int   busy_len  = 0;

   md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .mthl(mthl),
      .hl_sel(hl_sel), .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: counts busy cycles and checks the scoreboard head on every completion.
   always @(negedge clk) begin
      if (reset) begin
         prev_busy = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy) busy_len++;
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_completion: hi=0x%08h lo=0x%08h, expected none", hi, lo);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check32({e.name, "_hi"}, hi, e.hi);
               check32({e.name, "_lo"}, lo, e.lo);
               check32({e.name, "_busy_len"}, 32'(busy_len), 32'(e.lat));
            end
            busy_len = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic issue(input string name, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit expect_it);
      exp_t e;
      e.name = name;
      e.hi   = ehi;
      e.lo   = elo;
      e.lat  = op[1] ? 10 : 5;
      if (expect_it) exp_q.push_back(e);
      start = 1'b1;
      md_op = op;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_mthl(input logic sel, input logic [31:0] x);
      mthl   = 1'b1;
      hl_sel = sel;
      a      = x;
      @(posedge clk);
      #1;
      mthl = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy || exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d, expected idle", name, busy, exp_q.size());
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_op = 2'b00; mthl = 1'b0; hl_sel = 1'b0;
      a = 32'd0; b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_hi", hi, 32'd0);
      check32("reset_lo", lo, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-divide: preload HI/LO, start a div, hit reset when cnt is 4.
      do_mthl(1'b1, 32'hAAAA5555);
      do_mthl(1'b0, 32'h5555AAAA);
      issue("aborted_div", 2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check32("async_reset_busy", {31'd0, busy}, 32'd0);
      check32("async_reset_hi", hi, 32'd0);
      check32("async_reset_lo", lo, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check32("no_late_write_hi", hi, 32'd0);
      check32("no_late_write_lo", lo, 32'd0);

      issue("mult_neg", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
      wait_idle("mult_neg");
      issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
      wait_idle("multu_max");
      issue("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
      wait_idle("div_neg");
      issue("divu_zero", 2'b11, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
      wait_idle("divu_zero");
      issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1);
      wait_idle("div_ovf");

      do_mthl(1'b1, 32'h12345678);
      check32("mthi_hi", hi, 32'h12345678);
      check32("mthi_lo_kept", lo, 32'h80000000);
      do_mthl(1'b0, 32'hCAFEBABE);
      check32("mtlo_lo", lo, 32'hCAFEBABE);
      check32("mtlo_hi_kept", hi, 32'h12345678);

      // start and mthl together: mthl must not write HI with the operand.
      mthl = 1'b1;
      hl_sel = 1'b1;
      issue("mult_vs_mthl", 2'b00, 32'h10, 32'h20, 32'h0, 32'h200, 1'b1);
      mthl = 1'b0;
      check32("mthl_dropped_hi", hi, 32'h12345678);
      check32("mthl_dropped_busy", {31'd0, busy}, 32'd1);
      wait_idle("mult_vs_mthl");

      // Start and mthl while busy are ignored; result keeps its original schedule.
      issue("mult_busy", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      mthl = 1'b1;
      hl_sel = 1'b0;
      issue("ignored", 2'b10, 32'd100, 32'd5, 32'd0, 32'd0, 1'b0);
      mthl = 1'b0;
      check32("busy_mthl_ignored_lo", lo, 32'h200);
      while (busy) begin
         @(posedge clk);
         #1;
      end
      // Back-to-back: start in the very first idle cycle.
      issue("divu_b2b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      wait_idle("divu_b2b");
      issue("div_negdiv", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1);
      wait_idle("div_negdiv");

      repeat (3) @(posedge clk);
      check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
